// File: rtl/instruction_fetcher.sv
// ============================================================================
// Module      : instruction_fetcher
// Description : Core-side instruction fetch unit. Accepts a fetch request from
//               the core controller (fetcher_reset low + pc). Reads one 32-bit
//               word from instruction memory over a valid/ready handshake, and
//               holds the word with fetcher_completed until the core releases
//               the request.
//               Define INSTRUCTION_FETCHER_CACHE_EN to add a 16-entry
//               direct-mapped cache, so repeated fetches complete without a
//               memory transaction.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module instruction_fetcher (
    input  logic        clk,
    input  logic        reset,
    input  logic        fetcher_reset,
    input  logic [31:0] pc,
    output logic        fetcher_completed,
    output logic [31:0] instruction,
    output logic [31:0] inst_mem_addr,
    output logic        inst_mem_valid,
    input  logic [31:0] inst_mem_data,
    input  logic        inst_mem_ready
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t      r_state;
    logic        r_completed;
    logic        r_valid;
    logic [31:0] r_instruction;
    logic [31:0] r_addr;

    // A memory response is taken only when the request is still wanted.
    // An abort in the same cycle discards the data.
    logic        w_capture;
    assign w_capture = (r_state == S_REQ) && !fetcher_reset && inst_mem_ready;

    logic        w_hit;
    logic [31:0] w_hit_data;

    // The byte offset within the word never affects the fetch.
    logic [1:0]  w_unused_pc;
    assign w_unused_pc = pc[1:0];

`ifdef INSTRUCTION_FETCHER_CACHE_EN
    localparam int c_LINES = 16;

    logic [25:0]        r_tag        [0:c_LINES-1];
    logic [31:0]        r_data       [0:c_LINES-1];
    logic [c_LINES-1:0] r_line_valid;

    logic [3:0]  w_lookup_idx;
    logic [3:0]  w_fill_idx;
    assign w_lookup_idx = pc[5:2];
    assign w_fill_idx   = r_addr[5:2];

    // The lookup uses the live pc. It only matters in IDLE, on the edge where
    // the request is accepted.
    assign w_hit      = r_line_valid[w_lookup_idx] && (r_tag[w_lookup_idx] == pc[31:6]);
    assign w_hit_data = r_data[w_lookup_idx];

    // Only the valid bits need a reset. The tag and data arrays are qualified
    // by them and stay reset-free, so they can map onto plain storage.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_line_valid <= '0;
        end else if (w_capture) begin
            r_line_valid[w_fill_idx] <= 1'b1;
        end
    end

    // Each completed miss unconditionally replaces the indexed line.
    always_ff @(posedge clk) begin
        if (!reset && w_capture) begin
            r_tag[w_fill_idx]  <= r_addr[31:6];
            r_data[w_fill_idx] <= inst_mem_data;
        end
    end
`else
    assign w_hit      = 1'b0;
    assign w_hit_data = 32'h0000_0000;
`endif

    // Fetch sequencer. All outputs come from registers so that no input
    // reaches an output combinationally.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state       <= S_IDLE;
            r_completed   <= 1'b0;
            r_valid       <= 1'b0;
            r_instruction <= 32'h0000_0000;
            r_addr        <= 32'h0000_0000;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_completed <= 1'b0;
                    r_valid     <= 1'b0;
                    if (!fetcher_reset) begin
                        r_addr <= {pc[31:2], 2'b00};
                        if (w_hit) begin
                            r_instruction <= w_hit_data;
                            r_completed   <= 1'b1;
                            r_state       <= S_DONE;
                        end else begin
                            r_valid <= 1'b1;
                            r_state <= S_REQ;
                        end
                    end
                end
                S_REQ: begin
                    if (fetcher_reset) begin
                        r_valid <= 1'b0;
                        r_state <= S_IDLE;
                    end else if (inst_mem_ready) begin
                        r_instruction <= inst_mem_data;
                        r_valid       <= 1'b0;
                        r_completed   <= 1'b1;
                        r_state       <= S_DONE;
                    end
                end
                S_DONE: begin
                    if (fetcher_reset) begin
                        r_completed <= 1'b0;
                        r_state     <= S_IDLE;
                    end
                end
                default: begin
                    r_completed <= 1'b0;
                    r_valid     <= 1'b0;
                    r_state     <= S_IDLE;
                end
            endcase
        end
    end

    assign fetcher_completed = r_completed;
    assign instruction       = r_instruction;
    assign inst_mem_addr     = r_addr;
    assign inst_mem_valid    = r_valid;

endmodule

`default_nettype wire

// File: tb/tb_instruction_fetcher.sv
// ============================================================================
// Module      : tb_instruction_fetcher
// Description : Self-checking bench for instruction_fetcher. A table of
//               directed fetches is followed by hand-written reset and abort
//               sequences.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_instruction_fetcher;

    logic        clk;
    logic        reset;
    logic        fetcher_reset;
    logic [31:0] pc;
    logic        fetcher_completed;
    logic [31:0] instruction;
    logic [31:0] inst_mem_addr;
    logic        inst_mem_valid;
    logic [31:0] inst_mem_data;
    logic        inst_mem_ready;

    int n_tests;
    int n_fail;

    instruction_fetcher dut (
        .clk               (clk),
        .reset             (reset),
        .fetcher_reset     (fetcher_reset),
        .pc                (pc),
        .fetcher_completed (fetcher_completed),
        .instruction       (instruction),
        .inst_mem_addr     (inst_mem_addr),
        .inst_mem_valid    (inst_mem_valid),
        .inst_mem_data     (inst_mem_data),
        .inst_mem_ready    (inst_mem_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] data;       // word the memory returns if asked
        int          stall;      // ready-low cycles before acceptance
        logic [31:0] exp_addr;
        logic [31:0] exp_inst;
        logic        exp_hit;
    } vec_t;

    localparam int NV = 7;
    vec_t vecs [NV];

    // Advance one clock edge; inputs are driven and outputs sampled 1ns later.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // One complete fetch with a small memory model. Checks latency, the
    // request-cycle count, address stability, the returned word, the hold
    // while the request stays asserted, and the release.
    task automatic do_fetch(input vec_t v, input string tag);
        int          lat;
        int          vcnt;
        bit          done;
        bit          addr_bad;
        int          exp_lat;
        int          exp_vcnt;
        logic [31:0] held;
        exp_lat  = v.exp_hit ? 1 : v.stall + 2;
        exp_vcnt = v.exp_hit ? 0 : v.stall + 1;
        lat = 0; vcnt = 0; done = 0; addr_bad = 0;
        pc             = v.pc;
        inst_mem_data  = v.data;
        inst_mem_ready = 1'b0;
        fetcher_reset  = 1'b0;
        for (int c = 0; c < 40 && !done; c++) begin
            step();
            lat++;
            pc = ~v.pc;                       // later pc changes must be ignored
            if (inst_mem_valid) begin
                vcnt++;
                if (inst_mem_addr !== v.exp_addr) addr_bad = 1;
            end
            if (fetcher_completed) begin
                done = 1;
                inst_mem_ready = 1'b0;
            end else begin
                inst_mem_ready = inst_mem_valid && (vcnt > v.stall);
            end
        end
        if (!done) begin
            n_tests++;
            n_fail++;
            $display("FAIL %s timeout: completed never rose within 40 cycles", tag);
        end
        check({tag, " latency"}, 32'(lat), 32'(exp_lat));
        check({tag, " valid_cycles"}, 32'(vcnt), 32'(exp_vcnt));
        check({tag, " addr_stable_bad"}, {31'b0, addr_bad}, 32'h0);
        check({tag, " addr"}, inst_mem_addr, v.exp_addr);
        check({tag, " instruction"}, instruction, v.exp_inst);
        check({tag, " valid_at_done"}, {31'b0, inst_mem_valid}, 32'h0);
        held = instruction;
        inst_mem_data = 32'h5A5A_0F0F;
        step();
        step();
        check({tag, " completed_held"}, {31'b0, fetcher_completed}, 32'h1);
        check({tag, " instruction_held"}, instruction, held);
        fetcher_reset = 1'b1;
        step();
        check({tag, " completed_release"}, {31'b0, fetcher_completed}, 32'h0);
        check({tag, " instruction_after_release"}, instruction, held);
    endtask

    initial begin
        vec_t        av;
        logic [31:0] prev;
        n_tests = 0;
        n_fail  = 0;

        // pc, data, stall, exp_addr, exp_inst, exp_hit
`ifdef INSTRUCTION_FETCHER_CACHE_EN
        vecs[0] = '{32'h0000_0104, 32'hDEAD_BEEF, 0, 32'h0000_0104, 32'hDEAD_BEEF, 1'b0};
        vecs[1] = '{32'h0000_0203, 32'hCAFE_F00D, 3, 32'h0000_0200, 32'hCAFE_F00D, 1'b0};
        vecs[2] = '{32'h0000_0104, 32'h1111_1111, 0, 32'h0000_0104, 32'hDEAD_BEEF, 1'b1};
        vecs[3] = '{32'h0000_0144, 32'h2222_2222, 1, 32'h0000_0144, 32'h2222_2222, 1'b0};
        vecs[4] = '{32'h0000_0104, 32'h3333_3333, 0, 32'h0000_0104, 32'h3333_3333, 1'b0};
        vecs[5] = '{32'h0000_0107, 32'h4444_4444, 0, 32'h0000_0104, 32'h3333_3333, 1'b1};
        vecs[6] = '{32'hFFFF_FFFF, 32'hA5A5_A5A5, 2, 32'hFFFF_FFFC, 32'hA5A5_A5A5, 1'b0};
`else
        vecs[0] = '{32'h0000_0104, 32'hDEAD_BEEF, 0, 32'h0000_0104, 32'hDEAD_BEEF, 1'b0};
        vecs[1] = '{32'h0000_0203, 32'hCAFE_F00D, 3, 32'h0000_0200, 32'hCAFE_F00D, 1'b0};
        vecs[2] = '{32'h0000_0104, 32'h1111_1111, 0, 32'h0000_0104, 32'h1111_1111, 1'b0};
        vecs[3] = '{32'h0000_0144, 32'h2222_2222, 1, 32'h0000_0144, 32'h2222_2222, 1'b0};
        vecs[4] = '{32'h0000_0104, 32'h3333_3333, 0, 32'h0000_0104, 32'h3333_3333, 1'b0};
        vecs[5] = '{32'h0000_0107, 32'h4444_4444, 0, 32'h0000_0104, 32'h4444_4444, 1'b0};
        vecs[6] = '{32'hFFFF_FFFF, 32'hA5A5_A5A5, 2, 32'hFFFF_FFFC, 32'hA5A5_A5A5, 1'b0};
`endif

        // Reset dominates a pending request and a ready memory.
        reset          = 1'b1;
        fetcher_reset  = 1'b0;
        pc             = 32'h0000_0104;
        inst_mem_data  = 32'hFFFF_FFFF;
        inst_mem_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            check("reset completed", {31'b0, fetcher_completed}, 32'h0);
            check("reset valid", {31'b0, inst_mem_valid}, 32'h0);
            check("reset instruction", instruction, 32'h0);
            check("reset addr", inst_mem_addr, 32'h0);
        end
        reset = 1'b0;
        step();
        check("post-reset first request", {31'b0, inst_mem_valid}, 32'h1);
        check("post-reset addr", inst_mem_addr, 32'h0000_0104);
        // Withdraw while ready is high: abort wins, nothing is captured.
        fetcher_reset = 1'b1;
        step();
        check("post-reset abort valid", {31'b0, inst_mem_valid}, 32'h0);
        check("post-reset abort completed", {31'b0, fetcher_completed}, 32'h0);
        check("post-reset abort instruction", instruction, 32'h0);
        inst_mem_ready = 1'b0;
        step();

        // Table-driven fetches.
        for (int i = 0; i < NV; i++) begin
            do_fetch(vecs[i], $sformatf("vec%0d", i));
            step();
        end

        // Abort in the second request cycle with ready high.
        prev           = instruction;
        pc             = 32'h0000_0300;
        inst_mem_data  = 32'h9999_9999;
        inst_mem_ready = 1'b0;
        fetcher_reset  = 1'b0;
        step();
        check("abort first req valid", {31'b0, inst_mem_valid}, 32'h1);
        check("abort addr", inst_mem_addr, 32'h0000_0300);
        step();
        check("abort second req valid", {31'b0, inst_mem_valid}, 32'h1);
        fetcher_reset  = 1'b1;
        inst_mem_ready = 1'b1;
        step();
        check("abort valid dropped", {31'b0, inst_mem_valid}, 32'h0);
        check("abort completed", {31'b0, fetcher_completed}, 32'h0);
        check("abort instruction kept", instruction, prev);
        inst_mem_ready = 1'b0;
        step();
        check("abort completed later", {31'b0, fetcher_completed}, 32'h0);
        check("abort instruction later", instruction, prev);
        // The aborted address must not have been cached.
        av = '{32'h0000_0300, 32'h7777_7777, 0, 32'h0000_0300, 32'h7777_7777, 1'b0};
        do_fetch(av, "after_abort");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
